// File: rtl/numbotron_btn_pkg.sv
// Shared button types and default timings.
// Used by the press classifier and its counter.
package numbotron_btn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESSED = 3'd1,
    ST_HELD    = 3'd2,
    ST_GAP     = 3'd3,
    ST_SECOND  = 3'd4
  } btn_state_t;

  localparam logic [23:0] LONG_DEF   = 24'd12000000;
  localparam logic [23:0] REPEAT_DEF = 24'd3000000;
  localparam logic [23:0] DOUBLE_DEF = 24'd6000000;

  function automatic logic [23:0] max3(
    input logic [23:0] a,
    input logic [23:0] b,
    input logic [23:0] c
  );
    logic [23:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/press_classifier_if.sv
// Debounced edge inputs and classified press outputs.
// master drives edges, slave is the classifier.
interface press_classifier_if;
  logic onChangeOn;
  logic onChangeOff;
  logic shortPress;
  logic longPress;
  logic repeatPulse;
  logic doublePress;
  logic pressActive;

  modport master (
    output onChangeOn, onChangeOff,
    input  shortPress, longPress,
    input  repeatPulse, doublePress,
    input  pressActive
  );

  modport slave (
    input  onChangeOn, onChangeOff,
    output shortPress, longPress,
    output repeatPulse, doublePress,
    output pressActive
  );
endinterface

// File: rtl/btn_interval_counter.sv
// Shared interval counter with clear and
// terminal compares for the three windows.
module btn_interval_counter
  import numbotron_btn_pkg::*;
#(
  parameter logic [23:0] LONG_CYCLES   = LONG_DEF,
  parameter logic [23:0] REPEAT_CYCLES = REPEAT_DEF,
  parameter logic [23:0] DOUBLE_CYCLES = DOUBLE_DEF,
  parameter int          CW            = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic hit_long_o,
  output logic hit_rep_o,
  output logic hit_dbl_o
);

  localparam logic [CW-1:0] T_LONG =
    CW'(LONG_CYCLES - 24'd1);
  localparam logic [CW-1:0] T_REP =
    CW'(REPEAT_CYCLES - 24'd1);
  localparam logic [CW-1:0] T_DBL =
    CW'(DOUBLE_CYCLES - 24'd1);

  logic [CW-1:0] cnt_q, cnt_d;

  // clear wins over counting; idle states hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + CW'(1);
  end

  // counter register
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign hit_long_o = (cnt_q == T_LONG);
  assign hit_rep_o  = (cnt_q == T_REP);
  assign hit_dbl_o  = (cnt_q == T_DBL);

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced presses into short,
// long, auto-repeat and double events.
module press_classifier
  import numbotron_btn_pkg::*;
#(
  parameter logic [23:0] LONG_CYCLES   = LONG_DEF,
  parameter logic [23:0] REPEAT_CYCLES = REPEAT_DEF,
  parameter logic [23:0] DOUBLE_CYCLES = DOUBLE_DEF
) (
  input logic          clk,
  input logic          reset,
  press_classifier_if.slave bus
);

  localparam logic [23:0] MAXC =
    max3(LONG_CYCLES, REPEAT_CYCLES, DOUBLE_CYCLES);
  localparam int CW = $clog2(MAXC);

  if (LONG_CYCLES < 24'd2 ||
      REPEAT_CYCLES < 24'd2 ||
      DOUBLE_CYCLES < 24'd2) begin : g_bad_param
    $error("press_classifier: cycle params must be >= 2");
  end

  btn_state_t state_q, state_d;
  logic short_q, short_d;
  logic long_q, long_d;
  logic rep_q, rep_d;
  logic dbl_q, dbl_d;
  logic act_q, act_d;
  logic rep_clr;
  logic hit_long, hit_rep, hit_dbl;
  logic on_e, off_e;
  logic cnt_en, cnt_clr;

  // simultaneous edges cancel out
  assign on_e  = bus.onChangeOn  & ~bus.onChangeOff;
  assign off_e = bus.onChangeOff & ~bus.onChangeOn;

  assign cnt_en  = (state_q == ST_PRESSED) ||
                   (state_q == ST_HELD) ||
                   (state_q == ST_GAP);
  assign cnt_clr = (state_d != state_q) | rep_clr;

  btn_interval_counter #(
    .LONG_CYCLES   (LONG_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES),
    .DOUBLE_CYCLES (DOUBLE_CYCLES),
    .CW            (CW)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .en_i       (cnt_en),
    .clr_i      (cnt_clr),
    .hit_long_o (hit_long),
    .hit_rep_o  (hit_rep),
    .hit_dbl_o  (hit_dbl)
  );

  // next state and pulse requests; edges beat terminals
  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    dbl_d   = 1'b0;
    rep_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (on_e) state_d = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (off_e) begin
          state_d = ST_GAP;
        end else if (hit_long) begin
          state_d = ST_HELD;
          long_d  = 1'b1;
        end
      end
      ST_HELD: begin
        if (off_e) begin
          state_d = ST_IDLE;
        end else if (hit_rep) begin
          rep_d   = 1'b1;
          rep_clr = 1'b1;
        end
      end
      ST_GAP: begin
        if (on_e) begin
          state_d = ST_SECOND;
          dbl_d   = 1'b1;
        end else if (hit_dbl) begin
          state_d = ST_IDLE;
          short_d = 1'b1;
        end
      end
      ST_SECOND: begin
        if (off_e) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    act_d = (state_d == ST_PRESSED) ||
            (state_d == ST_HELD) ||
            (state_d == ST_SECOND);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      dbl_q   <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      short_q <= short_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      dbl_q   <= dbl_d;
      act_q   <= act_d;
    end
  end

  assign bus.shortPress  = short_q;
  assign bus.longPress   = long_q;
  assign bus.repeatPulse = rep_q;
  assign bus.doublePress = dbl_q;
  assign bus.pressActive = act_q;

endmodule
